tlc_ctrl: RTL and testbench

// Traffic-light controller FSM; master of the external down-counting timer.
// - On each state entry: loads the timer with the phase duration.
// - Leaves the state when the timer reads zero.
// - Drives main-road and side-road lamps. Side road is served only on request.

---
 rtl/tlc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_tlc_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_ctrl.sv
// tlc_ctrl: traffic-light FSM that loads and watches an external down-counting timer.
// Optional pedestrian WALK phase is compiled in with the TLC_PED_EN macro.
module tlc_ctrl #(
  parameter int N        = 4,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_RED    = 1,
  parameter int T_SIDE   = 6,
  parameter int T_WALK   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         side_req,
`ifdef TLC_PED_EN
  input  logic         ped_req,
  output logic         walk,
`endif
  input  logic [N-1:0] tmr_out,
  output logic         tmr_load,
  output logic [N-1:0] tmr_init,
  output logic         tmr_en,
  output logic [2:0]   main_lt,
  output logic [2:0]   side_lt
);

  localparam int TMAX = (1 << N) - 1;

  if (T_GREEN < 1 || T_GREEN > TMAX) begin : g_bad_green
    $error("tlc_ctrl: T_GREEN out of range");
  end
  if (T_YELLOW < 1 || T_YELLOW > TMAX) begin : g_bad_yellow
    $error("tlc_ctrl: T_YELLOW out of range");
  end
  if (T_RED < 1 || T_RED > TMAX) begin : g_bad_red
    $error("tlc_ctrl: T_RED out of range");
  end
  if (T_SIDE < 1 || T_SIDE > TMAX) begin : g_bad_side
    $error("tlc_ctrl: T_SIDE out of range");
  end
  if (T_WALK < 1 || T_WALK > TMAX) begin : g_bad_walk
    $error("tlc_ctrl: T_WALK out of range");
  end

  localparam logic [N-1:0] D_GREEN  = N'(T_GREEN);
  localparam logic [N-1:0] D_YELLOW = N'(T_YELLOW);
  localparam logic [N-1:0] D_RED    = N'(T_RED);
  localparam logic [N-1:0] D_SIDE   = N'(T_SIDE);
`ifdef TLC_PED_EN
  localparam logic [N-1:0] D_WALK   = N'(T_WALK);
`endif

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    ALL_RED_1,
    SIDE_GREEN,
    SIDE_YELLOW,
    ALL_RED_2
`ifdef TLC_PED_EN
    , WALK
`endif
  } state_t;

  state_t       r_state;
  state_t       w_nxt;
  logic         r_load;
  logic [N-1:0] r_init;
  logic         r_en;
  logic [2:0]   r_main;
  logic [2:0]   r_side;
  logic         r_req;
  logic         w_expired;
  logic         w_pending;
  logic         w_exit_main;
  logic         w_go;
  logic [5:0]   w_lamps;
  logic [N-1:0] w_dur;

`ifdef TLC_PED_EN
  logic r_ped;
  logic r_walk;
`endif

  // tmr_out is stale in the cycle the load strobe is out
  assign w_expired = (tmr_out == '0) && !r_load;
  assign w_pending = r_req | side_req;

`ifdef TLC_PED_EN
  assign w_exit_main = w_pending | r_ped | ped_req;
`else
  assign w_exit_main = w_pending;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      MAIN_GREEN: begin
        if (w_exit_main) w_nxt = MAIN_YELLOW;
      end
      MAIN_YELLOW: w_nxt = ALL_RED_1;
`ifdef TLC_PED_EN
      ALL_RED_1: w_nxt = w_pending ? SIDE_GREEN : WALK;
      ALL_RED_2: w_nxt = r_ped ? WALK : MAIN_GREEN;
      WALK:      w_nxt = ALL_RED_2;
`else
      ALL_RED_1: w_nxt = SIDE_GREEN;
      ALL_RED_2: w_nxt = MAIN_GREEN;
`endif
      SIDE_GREEN:  w_nxt = SIDE_YELLOW;
      SIDE_YELLOW: w_nxt = ALL_RED_2;
      default:     w_nxt = ALL_RED_2;
    endcase
    if (!w_expired) w_nxt = r_state;
  end

  // holding in MAIN_GREEN leaves w_nxt == r_state, so no reload
  assign w_go = w_expired && (w_nxt != r_state);

  always_comb begin
    w_lamps = {LR, LR};
    w_dur   = D_RED;
    unique case (w_nxt)
      MAIN_GREEN: begin
        w_lamps = {LG, LR};
        w_dur   = D_GREEN;
      end
      MAIN_YELLOW: begin
        w_lamps = {LY, LR};
        w_dur   = D_YELLOW;
      end
      SIDE_GREEN: begin
        w_lamps = {LR, LG};
        w_dur   = D_SIDE;
      end
      SIDE_YELLOW: begin
        w_lamps = {LR, LY};
        w_dur   = D_YELLOW;
      end
`ifdef TLC_PED_EN
      WALK: begin
        w_lamps = {LR, LR};
        w_dur   = D_WALK;
      end
`endif
      default: begin
        w_lamps = {LR, LR};
        w_dur   = D_RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ALL_RED_2;
      r_load  <= 1'b1;
      r_init  <= D_RED;
      r_en    <= 1'b0;
      r_main  <= LR;
      r_side  <= LR;
    end else begin
      r_state <= w_nxt;
      r_load  <= w_go;
      r_en    <= 1'b1;
      r_main  <= w_lamps[5:3];
      r_side  <= w_lamps[2:0];
      if (w_go) r_init <= w_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else if (w_go && (w_nxt == SIDE_GREEN)) begin
      r_req <= 1'b0;
    end else if (side_req) begin
      r_req <= 1'b1;
    end
  end

`ifdef TLC_PED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped  <= 1'b0;
      r_walk <= 1'b0;
    end else begin
      r_walk <= (w_nxt == WALK);
      if (w_go && (w_nxt == WALK)) r_ped <= 1'b0;
      else if (ped_req)            r_ped <= 1'b1;
    end
  end

  assign walk = r_walk;
`endif

  assign tmr_load = r_load;
  assign tmr_init = r_init;
  assign tmr_en   = r_en;
  assign main_lt  = r_main;
  assign side_lt  = r_side;

endmodule

// File: tb/tb_tlc_ctrl.sv
// tb_tlc_ctrl: bench for tlc_ctrl with a down-counting timer model, N=4.
// Startup vectors come from a table; phase entries are checked against a queue.
module tb_tlc_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       side_req;
  logic [3:0] tmr_out;
  logic       tmr_load;
  logic [3:0] tmr_init;
  logic       tmr_en;
  logic [2:0] main_lt;
  logic [2:0] side_lt;
  logic       clk_en = 1'b1;
`ifdef TLC_PED_EN
  logic       ped_req;
  logic       walk;
`endif

  tlc_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .side_req (side_req),
`ifdef TLC_PED_EN
    .ped_req  (ped_req),
    .walk     (walk),
`endif
    .tmr_out  (tmr_out),
    .tmr_load (tmr_load),
    .tmr_init (tmr_init),
    .tmr_en   (tmr_en),
    .main_lt  (main_lt),
    .side_lt  (side_lt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmr_out <= 4'd0;
    else if (tmr_load)                         tmr_out <= tmr_init;
    else if (tmr_en && clk_en && tmr_out != 0) tmr_out <= tmr_out - 4'd1;
  end

  typedef struct {
    logic       req;
    logic       ld;
    logic [3:0] init;
    logic       en;
    logic [2:0] m;
    logic [2:0] s;
  } vec_t;

  typedef struct {
    logic [2:0] m;
    logic [2:0] s;
    logic [3:0] init;
    int         gap;
    logic       wk;
  } phase_t;

  vec_t   vt[4];
  phase_t sb[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last = 0;
  int     n_load = 0;
  bit     mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic phase_t ph(input logic [2:0] m, input logic [2:0] s,
                                input logic [3:0] init, input int gap,
                                input logic wk);
    phase_t p;
    p.m = m; p.s = s; p.init = init; p.gap = gap; p.wk = wk;
    return p;
  endfunction

  // one clock; sample on the falling edge and score any load strobe
  task automatic step();
    phase_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (tmr_load) begin
      n_load++;
      if (mon_on) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_load cyc=%0d main=%b side=%b", cyc, main_lt, side_lt);
        end else begin
          e = sb.pop_front();
          chk("ph_main", main_lt, e.m);
          chk("ph_side", side_lt, e.s);
          chk("ph_init", tmr_init, e.init);
          if (e.gap != 0) chk("ph_gap", cyc - last, e.gap);
`ifdef TLC_PED_EN
          chk("ph_walk", walk, e.wk);
`endif
        end
      end
      last = cyc;
    end
  endtask

  task automatic drain(input int lim);
    for (int k = 0; k < lim && sb.size() != 0; k++) step();
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic startup();
    foreach (vt[i]) begin
      side_req = vt[i].req;
      step();
      chk("st_load", tmr_load, vt[i].ld);
      if (vt[i].ld) chk("st_init", tmr_init, vt[i].init);
      chk("st_en", tmr_en, vt[i].en);
      chk("st_main", main_lt, vt[i].m);
      chk("st_side", side_lt, vt[i].s);
    end
  endtask

  task automatic push_cycle(input int g0);
    sb.push_back(ph(Y, R, 4'd3, g0, 1'b0));
    sb.push_back(ph(R, R, 4'd1, 5, 1'b0));
    sb.push_back(ph(R, G, 4'd6, 3, 1'b0));
    sb.push_back(ph(R, Y, 4'd3, 8, 1'b0));
    sb.push_back(ph(R, R, 4'd1, 5, 1'b0));
    sb.push_back(ph(G, R, 4'd10, 3, 1'b0));
  endtask

  task automatic reset_checks();
    chk("rst_load", tmr_load, 1'b1);
    chk("rst_init", tmr_init, 4'd1);
    chk("rst_en", tmr_en, 1'b0);
    chk("rst_main", main_lt, R);
    chk("rst_side", side_lt, R);
  endtask

  initial begin
    bit found;
    int n0;
    vt[0] = '{req: 1'b0, ld: 1'b0, init: 4'd0,  en: 1'b1, m: R, s: R};
    vt[1] = '{req: 1'b0, ld: 1'b0, init: 4'd0,  en: 1'b1, m: R, s: R};
    vt[2] = '{req: 1'b0, ld: 1'b1, init: 4'd10, en: 1'b1, m: G, s: R};
    vt[3] = '{req: 1'b0, ld: 1'b0, init: 4'd0,  en: 1'b1, m: G, s: R};

    rst_n = 1'b0;
    side_req = 1'b0;
`ifdef TLC_PED_EN
    ped_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    startup();
    mon_on = 1'b1;

    // pulse request three cycles into green
    push_cycle(12);
    step();
    step();
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    drain(100);

    // request lands in the cycle the timer first reads zero
    push_cycle(12);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = (tmr_out == 0) && !tmr_load;
    end
    chk("t4_zero_seen", found, 1'b1);
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    chk("t4_yel_main", main_lt, Y);
    chk("t4_yel_load", tmr_load, 1'b1);
    drain(100);

    // no request: green holds with the timer parked at zero
    n0 = n_load;
    for (int k = 0; k < 100; k++) step();
    chk("hold_main", main_lt, G);
    chk("hold_side", side_lt, R);
    chk("hold_tmr", tmr_out, 4'd0);
    chk("hold_loads", n_load - n0, 0);

    // reset asserted between edges in SIDE_GREEN
    sb.push_back(ph(Y, R, 4'd3, 0, 1'b0));
    sb.push_back(ph(R, R, 4'd1, 5, 1'b0));
    sb.push_back(ph(R, G, 4'd6, 3, 1'b0));
    side_req = 1'b1;
    step();
    side_req = 1'b0;
    drain(40);
    step();
    step();
    chk("t5_pre_side", side_lt, G);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    sb.delete();
    mon_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    startup();
    mon_on = 1'b1;

`ifdef TLC_PED_EN
    sb.push_back(ph(Y, R, 4'd3, 12, 1'b0));
    sb.push_back(ph(R, R, 4'd1, 5, 1'b0));
    sb.push_back(ph(R, R, 4'd5, 3, 1'b1));
    sb.push_back(ph(R, R, 4'd1, 7, 1'b0));
    sb.push_back(ph(G, R, 4'd10, 3, 1'b0));
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    drain(100);
    chk("ped_walk_off", walk, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
